// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the digit-serial adder/subtractor.
package adder_pkg;

    // FSM state encoding, kept as plain constants so older netlists and
    // scripts that probe the raw state bits keep working.
    //  state | meaning
    //  IDLE  | waiting for an operand pair, in_ready=1
    //  RUN   | one digit of the sum produced per clock, busy=1
    //  DONE  | result held until the consumer takes it, out_valid=1
    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    // Number of RUN cycles needed to walk the whole operand.
    function automatic int digit_count(input int width, input int digit);
        return width / digit;
    endfunction

    // Digit counter width; one spare bit so the count of digits itself fits.
    function automatic int cnt_width(input int width, input int digit);
        return $clog2(digit_count(width, digit)) + 1;
    endfunction

endpackage

// File: rtl/fa_slice.sv
// DIGIT-bit ripple-carry adder built from full-adder cells. Purely
// combinational; the serial adder reuses it every clock on the low digit of
// its shifted operands.
module fa_slice #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_top
);

    logic [DIGIT:0] c;

    assign c[0] = ci;

    // One full-adder cell per bit, carry rippling upward.
    for (genvar i = 0; i < DIGIT; i++) begin : g_cell
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co    = c[DIGIT];
    // Carry into the top bit of the digit; on the final digit this is the
    // carry into the operand MSB, needed for signed overflow.
    assign c_top = c[DIGIT-1];

endmodule

// File: rtl/adder_serial_n.sv
// Digit-serial adder/subtractor. Operands are accepted through a valid/ready
// handshake, summed DIGIT bits per clock LSB first, and the result is held
// behind a second valid/ready handshake.
//
//  state | meaning
//  IDLE  | accepting operands (in_ready=1)
//  RUN   | adding one digit per clock, WIDTH/DIGIT cycles (busy=1)
//  DONE  | S/cout/ovf valid and frozen until out_ready (out_valid=1)
module adder_serial_n
    import adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NDIG  = digit_count(WIDTH, DIGIT);
    localparam int CNT_W = cnt_width(WIDTH, DIGIT);
    localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

    // A partial final digit would silently drop the top operand bits.
    if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
        $error("adder_serial_n: WIDTH must be a positive multiple of DIGIT");
    end

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_reg;
    logic [WIDTH-1:0] s_next;
    logic             carry;
    logic [CNT_W-1:0] dig_cnt;
    logic             cout_r;
    logic             ovf_r;

    logic [DIGIT-1:0] dig_sum;
    logic             dig_co;
    logic             dig_ctop;

    fa_slice #(
        .DIGIT (DIGIT)
    ) u_fa_slice (
        .a     (a_sh[DIGIT-1:0]),
        .b     (b_sh[DIGIT-1:0]),
        .ci    (carry),
        .s     (dig_sum),
        .co    (dig_co),
        .c_top (dig_ctop)
    );

    // New digit enters at the top of the sum register; after NDIG shifts the
    // first (least significant) digit has arrived at bit 0.
    always_comb begin
        s_next = s_reg >> DIGIT;
        s_next[WIDTH-1 -: DIGIT] = dig_sum;
    end

    // Handshake FSM plus the operand/sum shift registers and digit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            s_reg   <= '0;
            carry   <= 1'b0;
            dig_cnt <= '0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction is A + ~B + 1, with ci acting as borrow-in.
                        a_sh    <= a;
                        b_sh    <= sub ? ~b : b;
                        carry   <= ci ^ sub;
                        dig_cnt <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    s_reg   <= s_next;
                    a_sh    <= a_sh >> DIGIT;
                    b_sh    <= b_sh >> DIGIT;
                    carry   <= dig_co;
                    dig_cnt <= dig_cnt + 1'b1;
                    if (dig_cnt == LAST_DIG) begin
                        cout_r <= dig_co;
                        ovf_r  <= dig_ctop ^ dig_co;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state == RUN);
    assign out_valid = (state == DONE);
    assign S         = s_reg;
    assign cout      = cout_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_adder_serial_n.sv
// Self-checking bench for adder_serial_n: an 8-bit/1-bit-digit instance and a
// 16-bit/4-bit-digit instance, checked against an integer-arithmetic model.
module tb_adder_serial_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       iv8, ir8, ci8, sub8, ov8, or8, co8, of8, bz8;
    logic [7:0] a8, b8, s8;

    logic        iv16, ir16, ci16, sub16, ov16, or16, co16, of16, bz16;
    logic [15:0] a16, b16, s16;

    int checks = 0;
    int errors = 0;

    adder_serial_n #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .ci(ci8), .sub(sub8), .out_valid(ov8), .out_ready(or8), .S(s8),
        .cout(co8), .ovf(of8), .busy(bz8)
    );

    adder_serial_n #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
        .ci(ci16), .sub(sub16), .out_valid(ov16), .out_ready(or16), .S(s16),
        .cout(co16), .ovf(of16), .busy(bz16)
    );

    typedef struct {
        logic [15:0] s;
        logic        co;
        logic        ov;
    } res_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic       sub;
        logic [7:0] s;
        logic       co;
        logic       ov;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic res_t model(input int w, input longint a, input longint b,
                                   input bit ci, input bit sub);
        longint mask = (longint'(1) << w) - 1;
        longint half = longint'(1) << (w - 1);
        longint ur, sa, sb, sr;
        res_t r;
        ur   = sub ? (a - b - longint'(ci)) : (a + b + longint'(ci));
        r.s  = 16'(ur & mask);
        r.co = sub ? (ur >= 0) : (ur > mask);
        sa   = (a >= half) ? a - 2 * half : a;
        sb   = (b >= half) ? b - 2 * half : b;
        sr   = sub ? (sa - sb - longint'(ci)) : (sa + sb + longint'(ci));
        r.ov = (sr < -half) || (sr > half - 1);
        return r;
    endfunction

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                        input logic sub, output res_t r);
        int n;
        n = 0;
        while (!ir8 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("in_ready8_idle", ir8, 1);
        a8 = a; b8 = b; ci8 = ci; sub8 = sub; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        n = 0;
        while (!ov8 && n < 50) begin
            chk("busy8_run", bz8, 1);
            chk("in_ready8_run", ir8, 0);
            a8 = 8'($urandom); b8 = 8'($urandom);
            ci8 = 1'($urandom); sub8 = 1'($urandom); or8 = 1'($urandom);
            @(posedge clk); #1; n++;
        end
        chk("latency8", n, 8);
        r.s = {8'h00, s8}; r.co = co8; r.ov = of8;
        or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;
        chk("out_valid8_drop", ov8, 0);
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic ci,
                         input logic sub, output res_t r);
        int n;
        n = 0;
        while (!ir16 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("in_ready16_idle", ir16, 1);
        a16 = a; b16 = b; ci16 = ci; sub16 = sub; iv16 = 1'b1;
        @(posedge clk); #1;
        iv16 = 1'b0;
        n = 0;
        while (!ov16 && n < 50) begin
            chk("busy16_run", bz16, 1);
            a16 = 16'($urandom); b16 = 16'($urandom);
            @(posedge clk); #1; n++;
        end
        chk("latency16", n, 4);
        r.s = s16; r.co = co16; r.ov = of16;
        or16 = 1'b1;
        @(posedge clk); #1;
        or16 = 1'b0;
        chk("out_valid16_drop", ov16, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[6];
        res_t        r, e;
        res_t        q[$];
        int          acc_t[$];
        logic [7:0]  hs;
        logic        hco, hov;
        logic [7:0]  ra, rb;
        logic [15:0] wa, wb;
        logic        rc, rs, accepted;
        int          n, cyc, results;

        tbl[0] = '{8'h3C, 8'h5A, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[2] = '{8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0};
        tbl[3] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        tbl[4] = '{8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[5] = '{8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};

        rst = 1'b1;
        iv8 = 0; or8 = 0; a8 = 0; b8 = 0; ci8 = 0; sub8 = 0;
        iv16 = 0; or16 = 0; a16 = 0; b16 = 0; ci16 = 0; sub16 = 0;
        @(posedge clk); #1;
        chk("rst_S", s8, 0);
        chk("rst_cout", co8, 0);
        chk("rst_ovf", of8, 0);
        chk("rst_out_valid", ov8, 0);
        chk("rst_busy", bz8, 0);
        chk("rst_out_valid16", ov16, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("in_ready_after_rst", ir8, 1);

        // Directed vectors.
        for (int i = 0; i < 6; i++) begin
            run8(tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].sub, r);
            chk($sformatf("tbl%0d_S", i), r.s[7:0], tbl[i].s);
            chk($sformatf("tbl%0d_cout", i), r.co, tbl[i].co);
            chk($sformatf("tbl%0d_ovf", i), r.ov, tbl[i].ov);
        end

        // Random operands against the model.
        for (int i = 0; i < 30; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom); rs = 1'($urandom);
            e = model(8, longint'(ra), longint'(rb), rc, rs);
            run8(ra, rb, rc, rs, r);
            chk("rand8_S", r.s, e.s);
            chk("rand8_cout", r.co, e.co);
            chk("rand8_ovf", r.ov, e.ov);
        end

        // Backpressure: result frozen in DONE, in_valid ignored.
        a8 = 8'h3C; b8 = 8'h5A; ci8 = 0; sub8 = 0; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        n = 0;
        while (!ov8 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("bp_latency", n, 8);
        hs = s8; hco = co8; hov = of8;
        chk("bp_S", hs, 8'h96);
        for (int k = 0; k < 5; k++) begin
            iv8 = 1'(k % 2 == 0);
            a8 = 8'($urandom); b8 = 8'($urandom);
            @(posedge clk); #1;
            chk("bp_out_valid", ov8, 1);
            chk("bp_S_stable", s8, hs);
            chk("bp_cout_stable", co8, hco);
            chk("bp_ovf_stable", of8, hov);
            chk("bp_in_ready", ir8, 0);
        end
        iv8 = 1'b0;
        or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;
        chk("bp_release", ov8, 0);
        chk("bp_idle", ir8, 1);

        // Reset in the third RUN cycle aborts the operation.
        a8 = 8'h3C; b8 = 8'h5A; ci8 = 0; sub8 = 0; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_busy_before", bz8, 1);
        rst = 1'b1;
        #1;
        chk("mid_out_valid", ov8, 0);
        chk("mid_busy", bz8, 0);
        chk("mid_S", s8, 0);
        chk("mid_cout", co8, 0);
        chk("mid_ovf", of8, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("mid_in_ready", ir8, 1);
        run8(8'h01, 8'h01, 1'b0, 1'b0, r);
        chk("post_rst_S", r.s[7:0], 8'h02);

        // Wide-digit instance.
        run16(16'hFFFF, 16'h0001, 1'b1, 1'b0, r);
        chk("w16_S", r.s, 16'h0001);
        chk("w16_cout", r.co, 1);
        chk("w16_ovf", r.ov, 0);
        for (int i = 0; i < 15; i++) begin
            wa = 16'($urandom); wb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
            e = model(16, longint'(wa), longint'(wb), rc, rs);
            run16(wa, wb, rc, rs, r);
            chk("rand16_S", r.s, e.s);
            chk("rand16_cout", r.co, e.co);
            chk("rand16_ovf", r.ov, e.ov);
        end

        // Back-to-back streaming with out_ready tied high.
        or8 = 1'b1;
        iv8 = 1'b1;
        a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom); sub8 = 1'($urandom);
        cyc = 0;
        results = 0;
        while (cyc < 120) begin
            @(negedge clk);
            accepted = 1'b0;
            if (iv8 && ir8) begin
                q.push_back(model(8, longint'(a8), longint'(b8), ci8, sub8));
                acc_t.push_back(cyc);
                accepted = 1'b1;
            end
            if (ov8 && or8) begin
                if (q.size() == 0) begin
                    chk("b2b_unexpected_result", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("b2b_S", s8, e.s[7:0]);
                    chk("b2b_cout", co8, e.co);
                    chk("b2b_ovf", of8, e.ov);
                    results++;
                end
            end
            @(posedge clk); #1;
            cyc++;
            if (accepted) begin
                a8 = 8'($urandom); b8 = 8'($urandom);
                ci8 = 1'($urandom); sub8 = 1'($urandom);
            end
            if (cyc == 65) iv8 = 1'b0;
            if (cyc > 65 && q.size() == 0) break;
        end
        or8 = 1'b0;
        chk("b2b_drained", q.size(), 0);
        chk("b2b_count", results, acc_t.size());
        chk("b2b_enough", acc_t.size() >= 5, 1);
        for (int i = 1; i < acc_t.size(); i++) begin
            chk("b2b_spacing", acc_t[i] - acc_t[i-1], 10);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_serial_n.md
Name: adder_serial_n

Overview:
Parametrised multi-cycle adder/subtractor built around a DIGIT-bit full-adder slice that is reused every clock. It accepts a WIDTH-bit operand pair through a valid/ready handshake and processes DIGIT bits per cycle, LSB first. It returns sum, carry-out and signed overflow through a second valid/ready handshake. It is the area-lean successor to the single-bit full adder, for datapaths where latency is cheaper than a WIDTH-bit carry chain.

Parameters:
WIDTH, 8, operand/sum width in bits; must be a multiple of DIGIT.
DIGIT, 1, bits processed per clock; legal range 1..WIDTH.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
ci  input  1  carry-in (add) / borrow-complement carry-in (sub)
sub  input  1  0 = A+B+ci, 1 = A+~B+(ci^1), i.e. A-B-ci
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
S  output  WIDTH  sum/difference
cout  output  1  carry out of MSB; for sub, 1 = no borrow
ovf  output  1  signed overflow, computed as carry into MSB XOR carry out of MSB
busy  output  1  high in RUN

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- FSM states:
  - IDLE: in_ready=1.
  - RUN: busy=1.
  - DONE: out_valid=1.
- Reset (async): state=IDLE; S=0, cout=0, ovf=0, out_valid=0, busy=0; in_ready=1 once rst deasserts.
- IDLE -> RUN on in_valid & in_ready at the clock edge:
  - latch A_sh=a and B_sh=(sub ? ~b : b);
  - carry=ci^sub;
  - digit counter=0.
- RUN, each cycle:
  - DIGIT-bit ripple add of A_sh[DIGIT-1:0], B_sh[DIGIT-1:0] and carry;
  - shift the result digit into the sum register from the top;
  - shift the operands right by DIGIT;
  - carry <= digit carry-out;
  - capture the carry into the MSB on the last digit.
- RUN -> DONE after exactly WIDTH/DIGIT RUN cycles. out_valid rises WIDTH/DIGIT cycles after the accept edge (WIDTH=8, DIGIT=1: 8 cycles).
- DONE: S, cout and ovf are registered and stable while out_valid=1 and out_ready=0. in_ready=0 during RUN and DONE; in_valid is ignored.
- DONE -> IDLE on out_ready. out_valid drops on the next edge. The next accept can occur no earlier than the following cycle (no same-cycle turnaround). Throughput is 1 result per WIDTH/DIGIT+2 cycles.
- out_ready asserted outside DONE has no effect.
- Changes on a, b, ci or sub after acceptance have no effect on the result in flight.
- Reset asserted in RUN or DONE aborts the operation immediately. The result is discarded and outputs return to their reset values.
- WIDTH % DIGIT != 0 is illegal; flag it with an elaboration-time check.

Decomposition:
- Shared package adder_pkg holds:
  - FSM state typedef (IDLE, RUN, DONE);
  - an integer function returning the digit count, WIDTH/DIGIT;
  - the counter width constant, clog2 of the digit count plus 1.
- One sub-module, fa_slice #(DIGIT): combinational DIGIT-bit ripple adder built from full-adder cells. Outputs are digit sum, carry out, and carry into the top bit (used for ovf on the last digit).
- The FSM, shift registers and counter live in adder_serial_n.

Test Plan:
- WIDTH=8, DIGIT=1, add 8'h3C+8'h5A, ci=0 -> after 8 cycles S=8'h96, cout=0, ovf=1. WIDTH=8, DIGIT=1, add 8'hFF+8'h01 -> S=8'h00, cout=1, ovf=0.
- WIDTH=8, DIGIT=1, sub 8'h10-8'h20, ci=0 -> S=8'hF0, cout=0 (borrow), ovf=0. Sub 8'h80-8'h01 -> S=8'h7F, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, S/cout/ovf unchanged, in_ready=0. in_valid pulses in that window are ignored.
- Reset mid-op: assert rst on the 3rd RUN cycle of 8'h3C+8'h5A -> immediately out_valid=0, busy=0, S=0. After release, in_ready=1, and 8'h01+8'h01 returns S=8'h02.
- WIDTH=16, DIGIT=4, add 16'hFFFF+16'h0001, ci=1 -> out_valid exactly 4 cycles after accept; S=16'h0001, cout=1, ovf=0.
- Back-to-back: in_valid held high with out_ready tied 1 -> accepts are spaced WIDTH/DIGIT+2 cycles apart, no operand is lost or duplicated, and results appear in order.
